// File: rtl/dot_product_acc.sv
// dot_product_acc: streaming signed N-lane dot product; 3-stage pipeline (multiply, tree, accumulate).
// Define DOT_SATURATE_EN for a saturating accumulator with sticky out_sat; default build wraps.
module dot_product_acc #(
  parameter int N          = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N*DATA_WIDTH-1:0] in_a,
  input  logic [N*DATA_WIDTH-1:0] in_b,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ACC_WIDTH-1:0]    out_data,
  output logic [CNT_WIDTH-1:0]    out_beats,
  output logic                    out_sat
);
  localparam int PW = 2 * DATA_WIDTH;
`ifdef DOT_SATURATE_EN
  // Keep the tree sum exact so an oversized single beat clips rather than wraps.
  localparam int TW = PW + $clog2(N) + 1;
  localparam int SW = (ACC_WIDTH > TW) ? ACC_WIDTH : TW;
`else
  localparam int SW = ACC_WIDTH;
`endif

  logic stall;
  logic accept;
  logic v1, l1, v2, l2;
  logic signed [PW-1:0]        prod_d [N];
  logic signed [PW-1:0]        prod_q [N];
  logic signed [SW-1:0]        sum_d, sum_q;
  logic signed [ACC_WIDTH-1:0] acc, acc_nxt;
  logic [CNT_WIDTH-1:0]        cnt;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~rst & ~stall;
  assign accept   = in_valid & in_ready;

  for (genvar i = 0; i < N; i++) begin : g_mul
    assign prod_d[i] = PW'($signed(in_a[i*DATA_WIDTH +: DATA_WIDTH]))
                     * PW'($signed(in_b[i*DATA_WIDTH +: DATA_WIDTH]));
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N; i++) sum_d = sum_d + SW'(prod_q[i]);
  end

`ifdef DOT_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  logic signed [SW:0] wide;
  logic clip_hi, clip_lo, clip, sat_q;

  assign wide    = (SW+1)'(acc) + (SW+1)'(sum_q);
  assign clip_hi = wide > (SW+1)'(ACC_MAX);
  assign clip_lo = wide < (SW+1)'(ACC_MIN);
  assign clip    = clip_hi | clip_lo;

  always_comb begin
    acc_nxt = wide[ACC_WIDTH-1:0];
    if (clip_hi) acc_nxt = ACC_MAX;
    if (clip_lo) acc_nxt = ACC_MIN;
  end

  // Sticky clip flag travels with the vector and is latched alongside the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_q   <= 1'b0;
      out_sat <= 1'b0;
    end else if (clear) begin
      sat_q <= 1'b0;
    end else if (!stall && v2) begin
      if (l2) begin
        out_sat <= sat_q | clip;
        sat_q   <= 1'b0;
      end else begin
        sat_q <= sat_q | clip;
      end
    end
  end
`else
  always_comb acc_nxt = acc + sum_q;
  assign out_sat = 1'b0;
`endif

  // Datapath registers carry no reset; the stage valids qualify them.
  always_ff @(posedge clk) begin
    if (!stall) begin
      prod_q <= prod_d;
      sum_q  <= sum_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v1        <= 1'b0;
      l1        <= 1'b0;
      v2        <= 1'b0;
      l2        <= 1'b0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_beats <= '0;
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (clear) begin
        v1  <= 1'b0;
        v2  <= 1'b0;
        acc <= '0;
        cnt <= '0;
      end else if (!stall) begin
        v1 <= accept;
        l1 <= in_last;
        v2 <= v1;
        l2 <= l1;
        if (v2) begin
          if (l2) begin
            out_data  <= acc_nxt;
            out_beats <= cnt + 1'b1;
            out_valid <= 1'b1;
            acc       <= '0;
            cnt       <= '0;
          end else begin
            acc <= acc_nxt;
            cnt <= cnt + 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_dot_product_acc.sv
// Bench for dot_product_acc: a 32-bit and a 16-bit accumulator instance share stimulus,
// a per-beat reference model feeds a result queue that is drained as outputs handshake.
module tb_dot_product_acc;
  localparam int N = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst, clear, in_valid, in_last, out_ready;
  logic [N*DW-1:0] in_a, in_b;
  logic in_ready, out_valid, out_sat;
  logic [31:0] out_data;
  logic [15:0] out_beats;
  logic in_ready16, out_valid16, out_sat16;
  logic [15:0] out_data16;
  logic [15:0] out_beats16;

  always #5 clk = ~clk;

  dot_product_acc #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_beats(out_beats), .out_sat(out_sat));

  dot_product_acc #(.N(N), .DATA_WIDTH(DW), .ACC_WIDTH(16), .CNT_WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready16),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_data(out_data16), .out_beats(out_beats16), .out_sat(out_sat16));

  typedef struct {
    longint d32;
    longint d16;
    longint beats;
    longint s32;
    longint s16;
  } exp_t;

  exp_t   sbq[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  int     n_out = 0;
  bit     rnd_mode = 0;
  longint m32 = 0, m16 = 0, mcnt = 0;
  bit     ms32 = 0, ms16 = 0;
  longint last32, last16, lastbeats, lastsat16;

  task automatic check_val(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrapn(input longint v, input int w);
    longint t;
    t = v <<< (64 - w);
    return t >>> (64 - w);
  endfunction

  task automatic addacc(input longint a, input longint s, input int w,
                        output longint r, output bit c);
`ifdef DOT_SATURATE_EN
    longint mx, mn, t;
    mx = (64'sd1 <<< (w - 1)) - 1;
    mn = -mx - 1;
    t  = a + s;
    c  = (t > mx) || (t < mn);
    r  = (t > mx) ? mx : ((t < mn) ? mn : t);
`else
    r = wrapn(a + s, w);
    c = 1'b0;
`endif
  endtask

  // Reference model and scoreboard, sampled away from the active edge.
  always @(negedge clk) begin
    if (rst) begin
      m32 = 0; m16 = 0; mcnt = 0; ms32 = 0; ms16 = 0;
      sbq.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check_val("unexpected_result", 1, 0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check_val("data32", longint'($signed(out_data)), e.d32);
          check_val("data16", longint'($signed(out_data16)), e.d16);
          check_val("beats", out_beats, e.beats);
          check_val("sat32", out_sat, e.s32);
          check_val("sat16", out_sat16, e.s16);
          check_val("valid16", out_valid16, 1);
        end
        last32 = $signed(out_data);
        last16 = $signed(out_data16);
        lastbeats = out_beats;
        lastsat16 = out_sat16;
        n_out++;
      end
      if (clear) begin
        m32 = 0; m16 = 0; mcnt = 0; ms32 = 0; ms16 = 0;
      end else if (in_valid && in_ready) begin
        longint bs, r32, r16;
        bit c32, c16;
        bs = 0;
        for (int i = 0; i < N; i++) begin
          longint x, y;
          x = $signed(in_a[i*DW +: DW]);
          y = $signed(in_b[i*DW +: DW]);
          bs += x * y;
        end
        addacc(m32, bs, 32, r32, c32);
        addacc(m16, bs, 16, r16, c16);
        if (in_last) begin
          exp_t e;
          e.d32 = r32; e.d16 = r16; e.beats = (mcnt + 1) % 65536;
          e.s32 = ms32 | c32; e.s16 = ms16 | c16;
          sbq.push_back(e);
          m32 = 0; m16 = 0; mcnt = 0; ms32 = 0; ms16 = 0;
        end else begin
          m32 = r32; m16 = r16; mcnt = (mcnt + 1) % 65536;
          ms32 = ms32 | c32; ms16 = ms16 | c16;
        end
      end
    end
  end

  function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] x);
    return {N{x}};
  endfunction

  // Called and returns at posedge+1; holds the beat until it is accepted.
  task automatic send(input logic [N*DW-1:0] a, input logic [N*DW-1:0] b, input logic last);
    bit done;
    done = 1'b0;
    in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      if (rnd_mode) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) check_val("send_timeout", 0, 1);
  endtask

  task automatic wait_out();
    in_valid = 1'b0;
    for (int i = 0; i < 64 && sbq.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    check_val("drain", sbq.size(), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 0);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_data", out_data, 0);
    check_val("rst_out_beats", out_beats, 0);
    check_val("rst_out_sat", out_sat, 0);
    rst = 1'b0;
    #1;
    check_val("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // 1: single beat, latency 3
    send({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5}, 1'b1);
    in_valid = 1'b0;
    check_val("t1_lat1", out_valid, 0);
    @(posedge clk); #1;
    check_val("t1_lat2", out_valid, 0);
    @(posedge clk); #1;
    check_val("t1_lat3", out_valid, 1);
    wait_out();
    check_val("t1_data", last32, 70);
    check_val("t1_beats", lastbeats, 1);

    // 2: three beats of -128 * -128, continuous valid
    for (int i = 0; i < 3; i++) begin
      check_val("t2_rdy", in_ready, 1);
      send(rep(8'h80), rep(8'h80), i == 2);
    end
    wait_out();
    check_val("t2_data", last32, 196608);
    check_val("t2_beats", lastbeats, 3);

    // 3: back-to-back results with downstream stalled
    n0 = n_out;
    out_ready = 1'b0;
    send(rep(8'd1), rep(8'd3), 1'b1);
    send(rep(8'd2), rep(8'hFF), 1'b1);
    in_valid = 1'b0;
    for (int i = 0; i < 20 && !out_valid; i++) begin
      @(posedge clk); #1;
    end
    in_a = rep(8'd1); in_b = rep(8'd1); in_last = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check_val("t3_stall_rdy", in_ready, 0);
      check_val("t3_stall_rdy16", in_ready16, 0);
      check_val("t3_hold", longint'($signed(out_data)), 12);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(rep(8'd1), rep(8'd1), 1'b1);
    wait_out();
    check_val("t3_count", n_out - n0, 3);
    check_val("t3_last", last32, 4);

    // 4: clear drops partial vector and a same-cycle beat
    send(rep(8'd5), rep(8'd5), 1'b0);
    send(rep(8'd5), rep(8'd5), 1'b0);
    in_valid = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    in_a = rep(8'd9); in_b = rep(8'd9); in_last = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    send(rep(8'd1), rep(8'd2), 1'b1);
    wait_out();
    check_val("t4_data", last32, 8);
    check_val("t4_beats", lastbeats, 1);

    // 5: overflow of the 16-bit accumulator
    for (int i = 0; i < 3; i++) send(rep(8'd127), rep(8'd127), i == 2);
    wait_out();
    check_val("t5_data32", last32, 193548);
`ifdef DOT_SATURATE_EN
    check_val("t5_data16", last16, 32767);
    check_val("t5_sat16", lastsat16, 1);
`else
    check_val("t5_data16", last16, -3060);
    check_val("t5_sat16", lastsat16, 0);
`endif

    // 6: reset mid-vector
    send(rep(8'd3), rep(8'd3), 1'b0);
    send(rep(8'd3), rep(8'd3), 1'b0);
    in_valid = 1'b0; rst = 1'b1;
    #1;
    check_val("t6_rdy_in_rst", in_ready, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_val("t6_out_valid", out_valid, 0);
    check_val("t6_out_data", out_data, 0);
    check_val("t6_out_beats", out_beats, 0);
    check_val("t6_rdy", in_ready, 1);
    @(posedge clk); #1;
    send({8'hFE, 8'd2, 8'hFF, 8'd1}, {8'd4, 8'd3, 8'd2, 8'd1}, 1'b1);
    wait_out();
    check_val("t6_data", last32, -3);
    check_val("t6_beats", lastbeats, 1);

    // 7: random stream with random downstream backpressure
    rnd_mode = 1'b1;
    for (int i = 0; i < 40; i++)
      send($urandom, $urandom, (i == 39) || ($urandom_range(0, 3) == 0));
    rnd_mode = 1'b0;
    out_ready = 1'b1;
    wait_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
